imem_dmem_arbiter: RTL and testbench

Single-port memory arbiter for the pipelined processor. The unified instruction/data memory has one port and three requesters: the IF-stage fetch, the MEM-stage load/store, and a debug/loader port used to preload programs and read results (e.g. writing a program at address 0, reading a result at address 198). The block grants exactly one requester per cycle and routes 1-cycle-latency read data back with a per-requester valid strobe. Starvation protection keeps instruction fetch from being locked out by back-to-back data accesses. A debug lock state gives the loader exclusive bursts.

---
 rtl/imem_dmem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imem_dmem_arbiter
//  Purpose  : Single-port memory arbiter for the unified instruction/data
//             memory of the pipelined processor. Three requesters share the
//             port: debug/loader (dbg), MEM-stage load/store (d) and IF-stage
//             fetch (i). Exactly one requester is granted per cycle, and
//             1-cycle-latency read data is returned with a per-requester
//             valid strobe.
//
//             - Normal priority: dbg > d > i.
//             - Fetch starvation guard: once fetch has been denied for
//               STARVE_MAX consecutive cycles, it is ranked above d
//               (never above dbg).
//             - Debug lock: a dbg grant with dbg_lock high moves the
//               arbiter into LOCK. Only dbg is served there, until
//               dbg_lock drops.
//
//  Ports    :
//    clk1                  clock, all state on rising edge
//    rst_n                 asynchronous active-low reset
//    dbg_req/we/addr/wdata debug/loader request
//    d_req/we/addr/wdata   data (MEM stage) request
//    i_req/we/addr         fetch request (i_we is ignored)
//    dbg_gnt/d_gnt/i_gnt   combinational single-cycle grants
//    dbg_rvalid/d_rvalid/i_rvalid  registered read-return strobes
//    dbg_lock              hold exclusive ownership for debug
//    rdata                 shared read data (pass-through of mem_rdata)
//    mem_en/we/addr/wdata  memory port, all zero when nothing is granted
//    mem_rdata             memory read data, one cycle after a read
//    starve_cnt            current fetch-starvation count
//
//  Revision : 1.0  initial release
// ============================================================================
module imem_dmem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk1,
    input  logic          rst_n,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    input  logic          dbg_lock,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,

    input  logic          i_req,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,

    output logic [DW-1:0] rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic [3:0]    starve_cnt
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       dbg_rvalid_q, d_rvalid_q, i_rvalid_q;

    logic       w_dbg_gnt, w_d_gnt, w_i_gnt;
    logic       w_starved;

    // Fetch never writes; the port exists only for interface symmetry.
    logic       w_unused_i_we;
    assign w_unused_i_we = i_we;

    assign w_starved = (starve_q == C_STARVE_MAX);

    // ------------------------------------------------------------------
    // Grant selection. Gated by rst_n so that no grant (and therefore no
    // memory access) can escape while reset is held low.
    // ------------------------------------------------------------------
    always_comb begin
        w_dbg_gnt = 1'b0;
        w_d_gnt   = 1'b0;
        w_i_gnt   = 1'b0;
        if (rst_n) begin
            if (dbg_req) begin
                w_dbg_gnt = 1'b1;
            end else if (state_q == ST_RUN) begin
                // A starved fetch outranks data, but never debug.
                if (i_req && w_starved) begin
                    w_i_gnt = 1'b1;
                end else if (d_req) begin
                    w_d_gnt = 1'b1;
                end else if (i_req) begin
                    w_i_gnt = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM next state. Entering LOCK needs an actual debug grant, so
    // raising dbg_lock alone has no effect.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (w_dbg_gnt && dbg_lock) begin
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (!dbg_lock) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles where fetch asks and
    // is refused, saturating at the threshold. Keeps counting in LOCK so
    // fetch is promoted immediately once the lock is released.
    // ------------------------------------------------------------------
    always_comb begin
        starve_d = starve_q;
        if (!i_req || w_i_gnt) begin
            starve_d = 4'd0;
        end else if (!w_starved) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Memory port mux, all-zero when idle.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (w_d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (w_i_gnt) begin
            mem_addr  = i_addr;
        end
    end

    assign mem_en = w_dbg_gnt | w_d_gnt | w_i_gnt;

    // ------------------------------------------------------------------
    // State registers. A reset while a read is in flight discards its
    // rvalid strobe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            starve_q     <= 4'd0;
            dbg_rvalid_q <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_rvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            dbg_rvalid_q <= w_dbg_gnt && !dbg_we;
            d_rvalid_q   <= w_d_gnt && !d_we;
            i_rvalid_q   <= w_i_gnt;
        end
    end

    assign dbg_gnt    = w_dbg_gnt;
    assign d_gnt      = w_d_gnt;
    assign i_gnt      = w_i_gnt;
    assign dbg_rvalid = dbg_rvalid_q;
    assign d_rvalid   = d_rvalid_q;
    assign i_rvalid   = i_rvalid_q;
    assign rdata      = mem_rdata;
    assign starve_cnt = starve_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_dmem_arbiter
//  Purpose  : Directed self-checking bench for imem_dmem_arbiter with a
//             1-cycle-latency memory model on the shared port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk1;
    logic          rst_n;
    logic          dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt, dbg_rvalid;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic          i_req, i_we;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [3:0]    starve_cnt;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks;
    int n_fail;

    imem_dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) u_dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_lock   (dbg_lock),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .rdata      (rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .starve_cnt (starve_cnt)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Single-port synchronous memory: read data one cycle after the access.
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk1);
        #1;
    endtask

    task automatic clear_reqs;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        d_req   = 1'b0; d_we   = 1'b0; d_addr   = '0; d_wdata   = '0;
        i_req   = 1'b0; i_addr = '0;
    endtask

    int exp_d_win [6] = '{1, 1, 1, 1, 0, 1};
    int exp_starve[6] = '{0, 1, 2, 3, 4, 0};

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mem_rdata = '0;
        for (int k = 0; k < (1 << AW); k++) mem[k] = 32'hA000_0000 + k;
        clear_reqs();
        i_we     = 1'b0;
        dbg_lock = 1'b0;
        rst_n    = 1'b0;

        // ---- Reset: requests present but nothing may be granted ----
        d_req = 1'b1; d_addr = 10'd198; i_req = 1'b1; i_addr = 10'd5;
        #2;
        check_eq("rst_d_gnt",   {31'd0, d_gnt},   32'd0);
        check_eq("rst_i_gnt",   {31'd0, i_gnt},   32'd0);
        check_eq("rst_mem_en",  {31'd0, mem_en},  32'd0);
        check_eq("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        check_eq("rst_starve",  {28'd0, starve_cnt}, 32'd0);
        check_eq("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        next_cyc(); next_cyc();
        clear_reqs();
        rst_n = 1'b1;

        // ---- Priority: dbg > d > i ----
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd200; dbg_wdata = 32'h55;
        d_req = 1'b1; d_addr = 10'd198;
        i_req = 1'b1; i_addr = 10'd5;
        #1;
        check_eq("pri_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
        check_eq("pri_d_gnt",   {31'd0, d_gnt},   32'd0);
        check_eq("pri_i_gnt",   {31'd0, i_gnt},   32'd0);
        check_eq("pri_mem_addr", {22'd0, mem_addr}, 32'd200);
        check_eq("pri_mem_we",  {31'd0, mem_we},  32'd1);
        next_cyc();
        check_eq("pri_starve1", {28'd0, starve_cnt}, 32'd1);
        check_eq("pri_dbg_rv",  {31'd0, dbg_rvalid}, 32'd0);
        dbg_req = 1'b0; dbg_we = 1'b0;
        #1;
        check_eq("pri2_d_gnt",  {31'd0, d_gnt},   32'd1);
        check_eq("pri2_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        check_eq("pri2_mem_addr", {22'd0, mem_addr}, 32'd198);
        next_cyc();
        check_eq("pri2_d_rv",   {31'd0, d_rvalid}, 32'd1);
        check_eq("pri2_rdata",  rdata, 32'hA000_00C6);
        check_eq("pri2_starve", {28'd0, starve_cnt}, 32'd2);
        d_req = 1'b0;
        #1;
        check_eq("pri3_i_gnt",  {31'd0, i_gnt},   32'd1);
        check_eq("pri3_mem_addr", {22'd0, mem_addr}, 32'd5);
        next_cyc();
        check_eq("pri3_i_rv",   {31'd0, i_rvalid}, 32'd1);
        check_eq("pri3_rdata",  rdata, 32'hA000_0005);
        check_eq("pri3_starve", {28'd0, starve_cnt}, 32'd0);
        check_eq("pri3_d_rv",   {31'd0, d_rvalid}, 32'd0);
        clear_reqs();

        // ---- Read return after a debug write ----
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd200; dbg_wdata = 32'd7;
        #1;
        check_eq("rr_mem_wdata", mem_wdata, 32'd7);
        next_cyc();
        check_eq("rr_dbg_rv_w", {31'd0, dbg_rvalid}, 32'd0);
        clear_reqs();
        d_req = 1'b1; d_addr = 10'd200;
        #1;
        check_eq("rr_d_gnt", {31'd0, d_gnt}, 32'd1);
        next_cyc();
        check_eq("rr_d_rv",   {31'd0, d_rvalid}, 32'd1);
        check_eq("rr_rdata",  rdata, 32'd7);
        check_eq("rr_dbg_rv", {31'd0, dbg_rvalid}, 32'd0);
        clear_reqs();
        next_cyc();

        // ---- Starvation: d and i held continuously ----
        d_req = 1'b1; d_addr = 10'd300; i_req = 1'b1; i_addr = 10'd10;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_eq($sformatf("stv%0d_cnt", k), {28'd0, starve_cnt}, exp_starve[k]);
            check_eq($sformatf("stv%0d_d_gnt", k), {31'd0, d_gnt}, exp_d_win[k]);
            check_eq($sformatf("stv%0d_i_gnt", k), {31'd0, i_gnt}, 32'(1 - exp_d_win[k]));
            next_cyc();
            check_eq($sformatf("stv%0d_d_rv", k), {31'd0, d_rvalid}, exp_d_win[k]);
        end
        check_eq("stv_end_cnt", {28'd0, starve_cnt}, 32'd1);
        clear_reqs();
        next_cyc();

        // ---- Debug lock burst while d and i request ----
        for (int k = 0; k < 11; k++) begin
            dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'(k); dbg_wdata = 32'(100 + k);
            dbg_lock = 1'b1;
            d_req = 1'b1; d_addr = 10'd300;
            i_req = 1'b1; i_addr = 10'd20;
            #1;
            check_eq($sformatf("lck%0d_dbg_gnt", k), {31'd0, dbg_gnt}, 32'd1);
            check_eq($sformatf("lck%0d_i_gnt", k), {31'd0, i_gnt}, 32'd0);
            check_eq($sformatf("lck%0d_d_gnt", k), {31'd0, d_gnt}, 32'd0);
            check_eq($sformatf("lck%0d_addr", k), {22'd0, mem_addr}, 32'(k));
            check_eq($sformatf("lck%0d_cnt", k), {28'd0, starve_cnt}, 32'((k < 4) ? k : 4));
            next_cyc();
        end
        dbg_req = 1'b0; dbg_we = 1'b0;
        #1;
        check_eq("lck_idle_en",  {31'd0, mem_en}, 32'd0);
        check_eq("lck_idle_i",   {31'd0, i_gnt},  32'd0);
        check_eq("lck_idle_d",   {31'd0, d_gnt},  32'd0);
        next_cyc();
        dbg_lock = 1'b0;
        #1;
        check_eq("lck_rel_en",   {31'd0, mem_en}, 32'd0);
        check_eq("lck_rel_cnt",  {28'd0, starve_cnt}, 32'd4);
        next_cyc();
        #1;
        check_eq("run_i_gnt",    {31'd0, i_gnt}, 32'd1);
        check_eq("run_d_gnt",    {31'd0, d_gnt}, 32'd0);
        check_eq("run_addr",     {22'd0, mem_addr}, 32'd20);
        next_cyc();
        check_eq("run_cnt",      {28'd0, starve_cnt}, 32'd0);
        check_eq("run_i_rv",     {31'd0, i_rvalid}, 32'd1);
        check_eq("run_rdata",    rdata, 32'hA000_0014);
        clear_reqs();
        next_cyc();

        // ---- dbg_lock without a dbg grant must not lock ----
        dbg_lock = 1'b1;
        d_req = 1'b1; d_addr = 10'd300;
        #1;
        check_eq("nolck_d_gnt0", {31'd0, d_gnt}, 32'd1);
        next_cyc();
        #1;
        check_eq("nolck_d_gnt1", {31'd0, d_gnt}, 32'd1);
        next_cyc();
        clear_reqs();
        dbg_lock = 1'b0;
        next_cyc();

        // ---- Debug readback of preloaded program word ----
        dbg_req = 1'b1; dbg_addr = 10'd3;
        #1;
        check_eq("dbgrd_gnt", {31'd0, dbg_gnt}, 32'd1);
        next_cyc();
        check_eq("dbgrd_rv",    {31'd0, dbg_rvalid}, 32'd1);
        check_eq("dbgrd_rdata", rdata, 32'd103);
        clear_reqs();

        // ---- Back-to-back fetch ----
        for (int k = 0; k < 3; k++) begin
            i_req = 1'b1; i_addr = 10'(k);
            #1;
            check_eq($sformatf("fet%0d_gnt", k), {31'd0, i_gnt}, 32'd1);
            check_eq($sformatf("fet%0d_addr", k), {22'd0, mem_addr}, 32'(k));
            next_cyc();
            check_eq($sformatf("fet%0d_rv", k), {31'd0, i_rvalid}, 32'd1);
            check_eq($sformatf("fet%0d_rdata", k), rdata, 32'(100 + k));
        end
        clear_reqs();
        #1;
        check_eq("fet_idle_gnt", {31'd0, i_gnt}, 32'd0);
        next_cyc();
        check_eq("fet_idle_rv",  {31'd0, i_rvalid}, 32'd0);

        // ---- Reset while a d read is returning ----
        d_req = 1'b1; d_addr = 10'd198; i_req = 1'b1; i_addr = 10'd7;
        #1;
        check_eq("mrst_d_gnt", {31'd0, d_gnt}, 32'd1);
        next_cyc();
        check_eq("mrst_d_rv_pre", {31'd0, d_rvalid}, 32'd1);
        check_eq("mrst_cnt_pre",  {28'd0, starve_cnt}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_d_rv",   {31'd0, d_rvalid}, 32'd0);
        check_eq("mrst_d_gnt0", {31'd0, d_gnt}, 32'd0);
        check_eq("mrst_i_gnt0", {31'd0, i_gnt}, 32'd0);
        check_eq("mrst_mem_en", {31'd0, mem_en}, 32'd0);
        check_eq("mrst_cnt",    {28'd0, starve_cnt}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
